battle_hp_datapath: RTL and testbench
=====================================

// Module: battle_hp_datapath
// PURPOSE
//  Datapath for the battle control FSM. Consumes its one-cycle command strobes.
//  Owns the player and AI HP registers and computes the damage, heal and catch results.
//  Produces the ai_dead, p_dead and catch_success inputs that the FSM branches on.
//  Displayed HP drains toward the new HP one point per tick, driving the HP bars.
// PARAMETERS
//  HP_W        8    width of every HP value
//  MAX_HP      100  full HP; reset/load value (must be < 2**HP_W)
//  P_ATK       12   player base damage dealt to AI
//  AI_ATK      10   AI base damage dealt to player
//  HEAL_AMT    20   HP restored per p_heal
//  CATCH_BIAS  16   added to AI HP to form the catch threshold
//  DMG_VAR_EN  1    1: add lfsr[2:0] (0..7) to each damage; 0: fixed damage
//  DRAIN_DIV   4    clk cycles per display step (>=1)
// PORTS
//  clk            in   1     system clock
//  reset_n        in   1     asynchronous active-low reset
//  load_ai_hp     in   1     strobe: AI HP target := MAX_HP
//  apply_ai_damage in  1     strobe: AI HP target -= player damage
//  apply_p_damage in   1     strobe: player HP target -= AI damage
//  p_heal         in   1     strobe: player HP target += HEAL_AMT
//  catch          in   1     strobe: catch attempt; increments catch_tries
//  p_hp           out  HP_W  displayed player HP
//  ai_hp          out  HP_W  displayed AI HP
//  p_dead         out  1     player fainted
//  ai_dead        out  1     AI fainted
//  catch_success  out  1     registered catch verdict, valid every cycle
//  catch_tries    out  4     saturating count of catch strobes
//  busy           out  1     any displayed HP differs from its target
// BEHAVIOUR
//  Reset (async, reset_n=0): p_tgt=p_hp=ai_tgt=ai_hp=MAX_HP; p_dead=ai_dead=0;
//   catch_success=0; catch_tries=0; busy=0; lfsr=8'hA5; drain counter=0.
//   Reset mid-drain abandons the drain immediately; no partial state survives.
//  LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle, never 0.
//  Damage: dmg = base + (DMG_VAR_EN ? lfsr[2:0] : 0), computed in HP_W+1 bits.
//   New target = (tgt > dmg) ? tgt-dmg : 0. Targets update on the edge after the strobe.
//  Heal: tgt = min(tgt+HEAL_AMT, MAX_HP), computed in HP_W+1 bits.
//  Same-cycle p_heal and apply_p_damage: apply heal first, then damage, in one update.
//  Same-cycle load_ai_hp and apply_ai_damage: load wins; damage is dropped.
//  Any strobe while busy is legal. It retargets immediately, and the display
//   keeps stepping from its current value toward the new target.
//  Drain: counter counts 0..DRAIN_DIV-1. On wrap (tick) each display moves one
//   step toward its target (±1). The counter runs only while busy and
//   clears to 0 when idle.
//   Latency: the first step occurs DRAIN_DIV cycles after a target change.
//  busy = (p_hp!=p_tgt)|(ai_hp!=ai_tgt), registered.
//  x_dead registered = (x_hp==0)&&(x_tgt==0). It asserts 1 cycle after the display
//   reaches 0. It clears only via reset (player) or load_ai_hp+refill (AI).
//  catch_success <= ({1'b0,lfsr} >= ai_tgt + CATCH_BIAS), 9-bit compare, every
//   cycle. This keeps it valid in the same cycle catch is high.
//   catch_tries saturates at 15.
// TESTING (MAX_HP=100, DMG_VAR_EN=0, DRAIN_DIV=4 unless stated)
//  1 reset -> p_hp=ai_hp=100, deads=0, busy=0, lfsr=8'hA5; async assert mid-cycle clears all.
//  2 apply_ai_damage pulse -> ai_tgt=88; busy next cycle; ai_hp 100->88 one step per 4 clks; busy drops at 88.
//  3 p_heal+apply_p_damage same cycle with p_tgt=95 -> p_tgt=90 (100-10); p_heal alone at 95 -> 100.
//  4 9 AI damage strobes -> ai_tgt clamps at 0 (no wrap); ai_dead=1 one cycle after ai_hp hits 0.
//  5 CATCH_BIAS=0, force ai_tgt=0 -> catch_success=1 every cycle; ai_tgt=100,BIAS=200 -> always 0.
//  6 16 catch strobes -> catch_tries=15; load_ai_hp+apply_ai_damage same cycle -> ai_tgt=100.

Source files
------------

// File: rtl/battle_hp_datapath.sv
// rtl/battle_hp_datapath.sv - HP targets, drained HP display, damage/heal/catch results for the battle FSM
// Targets move at once on a strobe; the displayed HP walks one point per drain tick toward them.
module battle_hp_datapath #(
  parameter int HP_W       = 8,
  parameter int MAX_HP     = 100,
  parameter int P_ATK      = 12,
  parameter int AI_ATK     = 10,
  parameter int HEAL_AMT   = 20,
  parameter int CATCH_BIAS = 16,
  parameter int DMG_VAR_EN = 1,
  parameter int DRAIN_DIV  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_ai_hp,
  input  logic            apply_ai_damage,
  input  logic            apply_p_damage,
  input  logic            p_heal,
  input  logic            catch,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic            p_dead,
  output logic            ai_dead,
  output logic            catch_success,
  output logic [3:0]      catch_tries,
  output logic            busy
);

  localparam int HW1   = HP_W + 1;
  localparam int DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam int CW    = (HP_W > 7) ? HP_W + 2 : 10;

  localparam logic [HP_W-1:0]  MAX_V    = HP_W'(MAX_HP);
  localparam logic [HW1-1:0]   MAX_W    = HW1'(MAX_HP);
  localparam logic [HW1-1:0]   HEAL_W   = HW1'(HEAL_AMT);
  localparam logic [HW1-1:0]   P_ATK_W  = HW1'(P_ATK);
  localparam logic [HW1-1:0]   AI_ATK_W = HW1'(AI_ATK);
  localparam logic [CW-1:0]    BIAS_W   = CW'(CATCH_BIAS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DRAIN_DIV - 1);

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] t, input logic [HW1-1:0] d);
    logic [HW1-1:0] te;
    te = {1'b0, t};
    return (te > d) ? HP_W'(te - d) : '0;
  endfunction

  function automatic logic [HP_W-1:0] heal_to(input logic [HP_W-1:0] t);
    logic [HW1-1:0] s;
    s = {1'b0, t} + HEAL_W;
    return (s > MAX_W) ? MAX_V : HP_W'(s);
  endfunction

  function automatic logic [HP_W-1:0] step_to(input logic [HP_W-1:0] h, input logic [HP_W-1:0] t);
    if (h < t)      return h + 1'b1;
    else if (h > t) return h - 1'b1;
    else            return h;
  endfunction

  logic [HP_W-1:0]  p_tgt_q, p_tgt_d, ai_tgt_q, ai_tgt_d;
  logic [HP_W-1:0]  p_hp_q, p_hp_d, ai_hp_q, ai_hp_d;
  logic             p_dead_q, p_dead_d, ai_dead_q, ai_dead_d;
  logic             catch_q, catch_d, busy_q, busy_d;
  logic [3:0]       tries_q, tries_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [HW1-1:0]   var_w, p_dmg, ai_dmg;
  logic             tick;

  always_comb begin
    var_w  = (DMG_VAR_EN != 0) ? HW1'(lfsr_q[2:0]) : '0;
    p_dmg  = P_ATK_W + var_w;
    ai_dmg = AI_ATK_W + var_w;

    // heal is applied before damage when both strobes land together
    p_tgt_d = p_tgt_q;
    if (p_heal)         p_tgt_d = heal_to(p_tgt_d);
    if (apply_p_damage) p_tgt_d = sat_sub(p_tgt_d, ai_dmg);

    ai_tgt_d = ai_tgt_q;
    if (load_ai_hp)           ai_tgt_d = MAX_V;
    else if (apply_ai_damage) ai_tgt_d = sat_sub(ai_tgt_q, p_dmg);

    // busy_q already equals "display differs from target" for the current state
    tick    = busy_q && (div_q == DIV_LAST);
    div_d   = (busy_q && !tick) ? div_q + 1'b1 : '0;
    p_hp_d  = tick ? step_to(p_hp_q, p_tgt_d) : p_hp_q;
    ai_hp_d = tick ? step_to(ai_hp_q, ai_tgt_d) : ai_hp_q;
    busy_d  = (p_hp_d != p_tgt_d) || (ai_hp_d != ai_tgt_d);

    p_dead_d  = p_dead_q || ((p_hp_q == '0) && (p_tgt_q == '0));
    ai_dead_d = load_ai_hp ? 1'b0 : (ai_dead_q || ((ai_hp_q == '0) && (ai_tgt_q == '0)));

    catch_d = ({{(CW-8){1'b0}}, lfsr_q} >= (CW'(ai_tgt_q) + BIAS_W));
    tries_d = (catch && (tries_q != 4'hF)) ? tries_q + 4'd1 : tries_q;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_tgt_q   <= MAX_V;
      ai_tgt_q  <= MAX_V;
      p_hp_q    <= MAX_V;
      ai_hp_q   <= MAX_V;
      p_dead_q  <= 1'b0;
      ai_dead_q <= 1'b0;
      catch_q   <= 1'b0;
      busy_q    <= 1'b0;
      tries_q   <= 4'd0;
      lfsr_q    <= 8'hA5;
      div_q     <= '0;
    end else begin
      p_tgt_q   <= p_tgt_d;
      ai_tgt_q  <= ai_tgt_d;
      p_hp_q    <= p_hp_d;
      ai_hp_q   <= ai_hp_d;
      p_dead_q  <= p_dead_d;
      ai_dead_q <= ai_dead_d;
      catch_q   <= catch_d;
      busy_q    <= busy_d;
      tries_q   <= tries_d;
      lfsr_q    <= lfsr_d;
      div_q     <= div_d;
    end
  end

  assign p_hp          = p_hp_q;
  assign ai_hp         = ai_hp_q;
  assign p_dead        = p_dead_q;
  assign ai_dead       = ai_dead_q;
  assign catch_success = catch_q;
  assign catch_tries   = tries_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_battle_hp_datapath.sv
// tb/tb_battle_hp_datapath.sv - directed scoreboard bench for battle_hp_datapath
module tb_battle_hp_datapath;

  logic clk = 1'b0;
  logic reset_n, load_ai_hp, apply_ai_damage, apply_p_damage, p_heal, catch;
  logic [7:0] p_hp, ai_hp, b0_p_hp, b0_ai_hp, b2_p_hp, b2_ai_hp;
  logic p_dead, ai_dead, catch_success, busy;
  logic b0_p_dead, b0_ai_dead, b0_catch, b0_busy;
  logic b2_p_dead, b2_ai_dead, b2_catch, b2_busy;
  logic [3:0] catch_tries, b0_tries, b2_tries;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] p;
    logic [7:0] ai;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  battle_hp_datapath #(.DMG_VAR_EN(0)) dut (
    .clk(clk), .reset_n(reset_n), .load_ai_hp(load_ai_hp), .apply_ai_damage(apply_ai_damage),
    .apply_p_damage(apply_p_damage), .p_heal(p_heal), .catch(catch),
    .p_hp(p_hp), .ai_hp(ai_hp), .p_dead(p_dead), .ai_dead(ai_dead),
    .catch_success(catch_success), .catch_tries(catch_tries), .busy(busy));

  battle_hp_datapath #(.DMG_VAR_EN(0), .CATCH_BIAS(0)) u_b0 (
    .clk(clk), .reset_n(reset_n), .load_ai_hp(load_ai_hp), .apply_ai_damage(apply_ai_damage),
    .apply_p_damage(apply_p_damage), .p_heal(p_heal), .catch(catch),
    .p_hp(b0_p_hp), .ai_hp(b0_ai_hp), .p_dead(b0_p_dead), .ai_dead(b0_ai_dead),
    .catch_success(b0_catch), .catch_tries(b0_tries), .busy(b0_busy));

  battle_hp_datapath #(.DMG_VAR_EN(0), .CATCH_BIAS(200)) u_b200 (
    .clk(clk), .reset_n(reset_n), .load_ai_hp(load_ai_hp), .apply_ai_damage(apply_ai_damage),
    .apply_p_damage(apply_p_damage), .p_heal(p_heal), .catch(catch),
    .p_hp(b2_p_hp), .ai_hp(b2_ai_hp), .p_dead(b2_p_dead), .ai_dead(b2_ai_dead),
    .catch_success(b2_catch), .catch_tries(b2_tries), .busy(b2_busy));

  // reference LFSR; m_lfsr_prev is the value the DUT used at the last edge
  logic [7:0] m_lfsr, m_lfsr_prev;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lfsr      <= 8'hA5;
      m_lfsr_prev <= 8'hA5;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic la, input logic aad, input logic apd, input logic ph, input logic ct);
    load_ai_hp = la; apply_ai_damage = aad; apply_p_damage = apd; p_heal = ph; catch = ct;
  endtask

  task automatic pulse(input logic la, input logic aad, input logic apd, input logic ph, input logic ct,
                       input int cycles);
    drive(la, aad, apd, ph, ct);
    repeat (cycles) @(negedge clk);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_settle"}, 32'(n < budget), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_p_hp"}, 32'(p_hp), 32'(e.p));
      chk({tag, "_ai_hp"}, 32'(ai_hp), 32'(e.ai));
    end
  endtask

  task automatic catch_window(input int n, input int tgt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("catch_b16", 32'(catch_success), 32'(int'(m_lfsr_prev) >= tgt + 16));
      chk("catch_b0", 32'(b0_catch), 32'(int'(m_lfsr_prev) >= tgt));
      chk("catch_b200", 32'(b2_catch), 32'(int'(m_lfsr_prev) >= tgt + 200));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_p_hp", 32'(p_hp), 32'd100);
    chk("rst_ai_hp", 32'(ai_hp), 32'd100);
    chk("rst_deads", 32'({p_dead, ai_dead}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_catch", 32'({catch_success, catch_tries}), 32'd0);
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'hA5);
    reset_n = 1'b1;
    catch_window(12, 100);

    // single AI hit: 100 -> 88, first display step 4 clocks after the target moves
    pulse(0, 1, 0, 0, 0, 1);
    sb.push_back('{p: 8'd100, ai: 8'd88});
    chk("dmg_ai_tgt", 32'(dut.ai_tgt_q), 32'd88);
    chk("dmg_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    chk("dmg_hold", 32'(ai_hp), 32'd100);
    @(negedge clk);
    chk("dmg_step1", 32'(ai_hp), 32'd99);
    wait_idle("dmg", 100);
    pop_check("dmg");
    catch_window(10, 88);

    // three player hits back to back, retargeting while busy
    pulse(0, 0, 1, 0, 0, 3);
    chk("p3_tgt", 32'(dut.p_tgt_q), 32'd70);
    sb.push_back('{p: 8'd70, ai: 8'd88});
    wait_idle("p3", 200);
    pop_check("p3");

    pulse(0, 0, 0, 1, 0, 1);
    chk("heal_tgt", 32'(dut.p_tgt_q), 32'd90);
    sb.push_back('{p: 8'd90, ai: 8'd88});
    wait_idle("heal", 200);
    pop_check("heal");

    // heal then damage in one update: min(110,100)-10 = 90
    pulse(0, 0, 1, 1, 0, 1);
    chk("heal_dmg_tgt", 32'(dut.p_tgt_q), 32'd90);
    chk("heal_dmg_busy", 32'(busy), 32'd0);

    pulse(0, 0, 0, 1, 0, 1);
    chk("heal_clamp_tgt", 32'(dut.p_tgt_q), 32'd100);
    sb.push_back('{p: 8'd100, ai: 8'd88});
    wait_idle("heal_clamp", 200);
    pop_check("heal_clamp");

    // nine AI hits clamp the target at 0
    pulse(0, 1, 0, 0, 0, 9);
    chk("ai9_tgt", 32'(dut.ai_tgt_q), 32'd0);
    sb.push_back('{p: 8'd100, ai: 8'd0});
    wait_idle("ai9", 500);
    pop_check("ai9");
    chk("ai_dead_lag", 32'(ai_dead), 32'd0);
    @(negedge clk);
    chk("ai_dead_set", 32'(ai_dead), 32'd1);
    chk("p_dead_clear", 32'(p_dead), 32'd0);
    catch_window(10, 0);

    pulse(0, 0, 0, 0, 1, 1);
    chk("tries_1", 32'(catch_tries), 32'd1);
    pulse(0, 0, 0, 0, 1, 15);
    chk("tries_sat", 32'(catch_tries), 32'd15);

    // load and damage together: load wins, AI revives
    pulse(1, 1, 0, 0, 0, 1);
    chk("load_tgt", 32'(dut.ai_tgt_q), 32'd100);
    chk("load_dead", 32'(ai_dead), 32'd0);
    sb.push_back('{p: 8'd100, ai: 8'd100});
    wait_idle("load", 500);
    pop_check("load");
    chk("load_dead_idle", 32'(ai_dead), 32'd0);

    // asynchronous reset in the middle of a drain
    pulse(0, 0, 1, 0, 0, 1);
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_p_hp", 32'(p_hp), 32'd100);
    chk("arst_p_tgt", 32'(dut.p_tgt_q), 32'd100);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tries", 32'(catch_tries), 32'd0);
    chk("arst_lfsr", 32'(dut.lfsr_q), 32'hA5);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_p_hp", 32'(p_hp), 32'd100);
    chk("post_rst_busy", 32'(busy), 32'd0);
    catch_window(4, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
